inv_mix_columns_seq: RTL
========================

# inv_mix_columns_seq

Iterative AES InvMixColumns unit for the decryption datapath; inverse of the forward MixColumns byte/column logic. Accepts a 128-bit state over a valid/ready handshake. Transforms it one 32-bit column per clock, four cycles in total, through a single shared inverse-column multiplier. Presents the result on a valid/ready output. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the decryption round.

## Interface
- No parameters; widths are fixed by AES (see shared package).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream presents state_in
- in_ready  out  1  unit can accept; high only in IDLE
- state_in  in  128  state; column c at [127-32c -: 32], row 0 byte at MSB of each column
- out_valid  out  1  state_out holds a complete result
- out_ready  in  1  downstream accepts
- state_out  out  128  InvMixColumns(state_in), same packing

## Operation
- State machine: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: register state_in into the working register, clear col_cnt to 0, go to BUSY.
- BUSY:
  - Each cycle, column col_cnt of the working register is replaced by inv_mix_col_word(column).
  - col_cnt increments each cycle. When col_cnt==3, that column is written, col_cnt wraps to 0, and the unit goes to DONE.
  - in_valid is ignored.
- DONE:
  - out_valid=1.
  - state_out = working register, stable until accepted.
  - On out_ready: go to IDLE.
- Per-column math, GF(2^8) modulo 0x11B, bytes a0..a3 with a0 at the MSB:
  - b0=0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3, then the row rotations for b1..b3 (b1=09·a0^0e·a1^0b·a2^0d·a3, and so on).
  - All products are built from xtime chains: x2, x4, x8. Multipliers are fixed constants, not a general multiplier.
- state_out is driven directly from the working register; outside DONE it is don't-care but must not glitch X.
- No back-to-back overlap: in_ready stays low from the accept edge until the cycle after out_valid&&out_ready.
- Reset (async assert, at any time including mid-BUSY):
  - FSM=IDLE, col_cnt=0, working register=0.
  - in_ready=1 after reset; out_valid=0; state_out=0.
  - Any in-flight block is discarded.
- Deassertion of rst_n is taken synchronously to clk by the instantiating design. The block does not synchronise it.

## Timing
- Accept edge T: in_valid&&in_ready sampled high.
- Columns 0..3 are written on edges T+1..T+4.
- out_valid rises after edge T+4, so latency is 4 cycles from accept to out_valid.
- Result held indefinitely while out_ready=0.
- If out_ready is already high when out_valid rises, the handshake completes on edge T+5. in_ready is high after T+5, and the next accept is possible at T+6.
- Throughput is one block per 6 cycles with no backpressure.
- in_valid asserted with rst_n low is ignored.

## Structure
- Shared package aes_pkg holds:
  - state_t (128-bit) and col_t (32-bit) typedefs
  - xtime function (shift left, conditional ^0x1B)
  - FSM state enum
  - constants STATE_W=128, COL_W=32, NCOLS=4
- Sub-module inv_mix_col_word: purely combinational, 32-bit in / 32-bit out, one column of InvMixColumns. Instantiated once and muxed by col_cnt.
- Top contains the FSM, col_cnt, working register and handshake logic.

## Test plan
- Single column (FIPS-197 MixColumns example, inverted):
  - state_in = 8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> state_out = db135345_f20a225c_01010101_d4d4d4d5.
  - out_valid exactly 4 cycles after accept.
- Fixed points: state_in all columns c6c6c6c6 or 01010101 -> state_out identical to input.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid: state_out stable, in_ready=0 throughout, and a second in_valid is not accepted.
  - Release out_ready: the next block is accepted one cycle later.
- Round-trip: 1000 random states passed through the forward MixColumns model then this unit -> output equals the original state.
- Reset mid-operation:
  - Assert rst_n=0 at BUSY col_cnt==2: out_valid=0, in_ready=1, state_out=0 immediately (asynchronous).
  - The next block after release produces the correct result with no residue from the aborted block.
- Back-to-back: in_valid and out_ready held high with two distinct vectors -> accepts 6 cycles apart, both results correct and in order.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the decryption datapath.
//   state_t / col_t : 128-bit state and 32-bit column words
//   fsm_t           : control states of the iterative InvMixColumns unit
//   xtime           : multiply-by-x in GF(2^8) mod 0x11B
package aes_pkg;

   localparam int STATE_W = 128;
   localparam int COL_W   = 32;
   localparam int NCOLS   = 4;

   typedef logic [STATE_W-1:0] state_t;
   typedef logic [COL_W-1:0]   col_t;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/inv_mix_col_word.sv
// One column of AES InvMixColumns, purely combinational.
//   col_in  : 32-bit column, row 0 byte in [31:24]
//   col_out : inverse-mixed column, same packing
// Constant products come from xtime chains: 9=8+1, b=8+2+1, d=8+4+1, e=8+4+2.
module inv_mix_col_word
   import aes_pkg::*;
(
   input  col_t col_in,
   output col_t col_out
);

   // Packed index 3 holds row 0 (the MSB byte).
   logic [3:0][7:0] a, m9, mb, md, me, b;

   assign a = col_in;

   for (genvar i = 0; i < 4; i++) begin : g_byte
      logic [7:0] x2, x4, x8;
      assign x2    = xtime(a[i]);
      assign x4    = xtime(x2);
      assign x8    = xtime(x4);
      assign m9[i] = x8 ^ a[i];
      assign mb[i] = x8 ^ x2 ^ a[i];
      assign md[i] = x8 ^ x4 ^ a[i];
      assign me[i] = x8 ^ x4 ^ x2;
   end

   // Row r: e*a[r] ^ b*a[r+1] ^ d*a[r+2] ^ 9*a[r+3], rows taken mod 4.
   for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int P0 = 3 - r;
      localparam int P1 = 3 - ((r + 1) % 4);
      localparam int P2 = 3 - ((r + 2) % 4);
      localparam int P3 = 3 - ((r + 3) % 4);
      assign b[P0] = me[P0] ^ mb[P1] ^ md[P2] ^ m9[P3];
   end

   assign col_out = b;

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: one column per clock through a single shared
// inverse-column multiplier, four cycles per 128-bit state.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake (ready only while idle)
//   state_in            : column c at [127-32c -: 32]
//   out_valid/out_ready : output handshake, result held until taken
//   state_out           : InvMixColumns(state_in), driven from the working register
module inv_mix_columns_seq
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out
);

   fsm_t       state, state_nxt;
   logic [1:0] col_cnt;
   state_t     work;
   col_t       col_sel, col_mix;

   always_comb begin
      col_sel = work[STATE_W-1 -: COL_W];
      case (col_cnt)
         2'd0: col_sel = work[STATE_W-1           -: COL_W];
         2'd1: col_sel = work[STATE_W-1 -   COL_W -: COL_W];
         2'd2: col_sel = work[STATE_W-1 - 2*COL_W -: COL_W];
         2'd3: col_sel = work[STATE_W-1 - 3*COL_W -: COL_W];
         default: ;
      endcase
   end

   inv_mix_col_word u_col (
      .col_in  (col_sel),
      .col_out (col_mix)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = BUSY;
         end
         BUSY: begin
            if (col_cnt == 2'd3) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // col_cnt wraps 3->0 on its own, so it is already cleared when DONE is reached.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work    <= '0;
         col_cnt <= 2'd0;
      end else if (state == IDLE && in_valid) begin
         work    <= state_in;
         col_cnt <= 2'd0;
      end else if (state == BUSY) begin
         case (col_cnt)
            2'd0: work[STATE_W-1           -: COL_W] <= col_mix;
            2'd1: work[STATE_W-1 -   COL_W -: COL_W] <= col_mix;
            2'd2: work[STATE_W-1 - 2*COL_W -: COL_W] <= col_mix;
            2'd3: work[STATE_W-1 - 3*COL_W -: COL_W] <= col_mix;
            default: ;
         endcase
         col_cnt <= col_cnt + 2'd1;
      end
   end

   assign state_out = work;

endmodule
